// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that serialises commands from NUM_REQ requesters onto one APB master port.
// Each accepted command becomes a SETUP/ACCESS transfer, bounded by a PREADY timeout.
module apb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  // state  | meaning
  // IDLE   | bus quiet, offering req_ready to the round-robin winner
  // SETUP  | PSEL high, PENABLE low, command presented for one cycle
  // ACCESS | PSEL/PENABLE high, waiting for PREADY or timeout
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] tmo_cnt;

  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic [IDX_W:0]   cand;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (PRESETn && (state == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      tmo_cnt    <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            state      <= SETUP;
            PSEL       <= 1'b1;
            PWRITE     <= req_write[grant_idx];
            PADDR      <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            PWDATA     <= req_wdata[grant_idx*DATA_W +: DATA_W];
            owner      <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          tmo_cnt <= CNT_W'(TIMEOUT - 1);
        end
        ACCESS: begin
          // Terminal count reached on the TIMEOUT-th ACCESS cycle without PREADY.
          if (PREADY || (tmo_cnt == '0)) begin
            state            <= IDLE;
            PSEL             <= 1'b0;
            PENABLE          <= 1'b0;
            tmo_cnt          <= '0;
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= PREADY ? PSLVERR : 1'b1;
            rsp_rdata        <= (PREADY && !PWRITE) ? PRDATA : '0;
          end else begin
            tmo_cnt <= tmo_cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_apb_master_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b1;
  logic [N-1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic          rsp_err, PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PRDATA = 32'hDEADBEEF;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b1;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Simple APB slave: PREADY rises after slv_wait ACCESS cycles unless slv_never.
  int            slv_wait = 0;
  logic          slv_never = 1'b0;
  logic          slv_err = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  int            acc_seen = 0;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      acc_seen = 0;
      PREADY   = 1'b0;
      PRDATA   = 32'hDEADBEEF;
      PSLVERR  = 1'b1;
    end else begin
      #1;
      if (PSEL && PENABLE) acc_seen++;
      else acc_seen = 0;
      PREADY  = PSEL && PENABLE && !slv_never && (acc_seen > slv_wait);
      PRDATA  = PREADY ? slv_rdata : 32'hDEADBEEF;
      PSLVERR = PREADY ? slv_err : 1'b1;
    end
  end

  // Transaction-level model: a transfer is "busy" from the cycle after acceptance until
  // it completes; the first busy cycle is setup, the rest are access cycles.
  logic          m_busy, m_setup, m_write;
  int            m_acc, m_last, m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [N-1:0]  m_pulse;
  logic [DW-1:0] m_rdata;
  logic          m_err;

  int            en_run = 0, obs_en_run = 0, obs_rsp_count = 0, obs_rsp_owner = -1;
  logic [DW-1:0] obs_rsp_rdata;
  logic          obs_rsp_err;
  logic [AW-1:0] obs_setup_addr;
  logic [DW-1:0] obs_setup_wdata;
  logic          obs_setup_write;
  int            obs_grants[$];

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge PCLK) begin
    logic [N-1:0] exp_ready;
    int g;
    if (!PRESETn) begin
      m_busy = 0; m_setup = 0; m_write = 0; m_acc = 0; m_last = N - 1; m_owner = 0;
      m_addr = '0; m_wdata = '0; m_pulse = '0; m_rdata = '0; m_err = 0;
      en_run = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end else begin
      g = m_busy ? -1 : rr_pick(m_last, req_valid);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("psel", PSEL, m_busy);
      chk("penable", PENABLE, m_busy && !m_setup);
      chk("paddr", PADDR, m_addr);
      chk("pwrite", PWRITE, m_write);
      chk("pwdata", PWDATA, m_wdata);
      chk("rsp_valid", rsp_valid, m_pulse);
      if (m_pulse != '0) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end

      if (PENABLE) en_run++;
      else if (en_run > 0) begin obs_en_run = en_run; en_run = 0; end
      if (PSEL && !PENABLE) begin
        obs_setup_addr = PADDR; obs_setup_wdata = PWDATA; obs_setup_write = PWRITE;
      end
      if (rsp_valid != '0) begin
        obs_rsp_count++;
        obs_rsp_owner = onehot_idx(rsp_valid);
        obs_rsp_rdata = rsp_rdata;
        obs_rsp_err   = rsp_err;
      end
      if ((req_valid & req_ready) != '0) obs_grants.push_back(onehot_idx(req_ready));

      m_pulse = '0;
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_setup = 1; m_owner = g; m_last = g;
          m_write = req_write[g]; m_addr = req_addr[g*AW +: AW]; m_wdata = req_wdata[g*DW +: DW];
        end
      end else if (m_setup) begin
        m_setup = 0; m_acc = 0;
      end else begin
        m_acc++;
        if (PREADY) begin
          m_busy = 0; m_pulse[m_owner] = 1'b1;
          m_err = PSLVERR; m_rdata = m_write ? '0 : PRDATA;
        end else if (m_acc == TMO) begin
          m_busy = 0; m_pulse[m_owner] = 1'b1;
          m_err = 1'b1; m_rdata = '0;
        end
      end
    end
  end

  // Requester driver: each requester holds valid until rem[i] commands are accepted.
  int rem[N];

  task automatic step();
    logic [N-1:0] acc;
    @(negedge PCLK);
    acc = req_valid & req_ready;
    @(posedge PCLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && PRESETn) begin
        rem[i]--;
        if (rem[i] <= 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int n);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    rem[i] = n;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (obs_rsp_count < target && n < budget) begin
      step();
      n++;
    end
    chk("rsp_within_budget", obs_rsp_count >= target, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_psel"}, PSEL, 0);
    chk({tag, "_penable"}, PENABLE, 0);
    chk({tag, "_pwrite"}, PWRITE, 0);
    chk({tag, "_paddr"}, PADDR, 0);
    chk({tag, "_pwdata"}, PWDATA, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  task automatic apply_reset(input string tag);
    #1;
    PRESETn = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(posedge PCLK);
    #3;
    PRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    req_valid[1] = 1'b1;
    apply_reset("rst0");
    req_valid = '0;
    step();

    // Single write from requester 0, zero wait states
    slv_wait = 0; slv_err = 0; slv_rdata = 32'h0BADF00D;
    issue(0, 1'b1, 8'h10, 32'hA5A5A5A5, 1);
    wait_rsp(1, 20);
    chk("wr_setup_addr", obs_setup_addr, 8'h10);
    chk("wr_setup_wdata", obs_setup_wdata, 32'hA5A5A5A5);
    chk("wr_setup_write", obs_setup_write, 1);
    chk("wr_owner", obs_rsp_owner, 0);
    chk("wr_err", obs_rsp_err, 0);
    chk("wr_rdata", obs_rsp_rdata, 0);
    chk("wr_access_cycles", obs_en_run, 1);
    repeat (2) step();

    // Read from requester 2 with 3 wait states
    slv_wait = 3; slv_rdata = 32'h12345678;
    issue(2, 1'b0, 8'h24, 32'h0, 1);
    wait_rsp(2, 30);
    chk("rd_setup_addr", obs_setup_addr, 8'h24);
    chk("rd_owner", obs_rsp_owner, 2);
    chk("rd_rdata", obs_rsp_rdata, 32'h12345678);
    chk("rd_err", obs_rsp_err, 0);
    chk("rd_access_cycles", obs_en_run, 4);
    repeat (2) step();

    // Round-robin from reset with all requesters valid
    apply_reset("rst1");
    step();
    obs_grants.delete();
    slv_wait = 0; slv_rdata = 32'hCAFE0001;
    base = obs_rsp_count;
    issue(0, 1'b1, 8'h30, 32'h00000030, 2);
    issue(1, 1'b0, 8'h31, 32'h0, 1);
    issue(2, 1'b1, 8'h32, 32'h00000032, 1);
    issue(3, 1'b0, 8'h33, 32'h0, 1);
    wait_rsp(base + 5, 60);
    chk("rr_grant_count", obs_grants.size(), 5);
    for (int i = 0; i < obs_grants.size() && i < 5; i++) chk($sformatf("rr_grant_%0d", i), obs_grants[i], exp_rr[i]);
    repeat (2) step();

    // Slave error
    slv_err = 1;
    base = obs_rsp_count;
    issue(1, 1'b1, 8'h40, 32'h11112222, 1);
    wait_rsp(base + 1, 20);
    chk("slverr_owner", obs_rsp_owner, 1);
    chk("slverr_err", obs_rsp_err, 1);
    slv_err = 0;
    repeat (2) step();

    // Timeout: PREADY never rises
    slv_never = 1;
    base = obs_rsp_count;
    issue(3, 1'b0, 8'h44, 32'h0, 1);
    wait_rsp(base + 1, 40);
    chk("tmo_owner", obs_rsp_owner, 3);
    chk("tmo_err", obs_rsp_err, 1);
    chk("tmo_rdata", obs_rsp_rdata, 0);
    chk("tmo_access_cycles", obs_en_run, 16);
    slv_never = 0;
    repeat (2) step();

    // Requester 0 raises then drops valid while the bus is busy: never granted
    slv_wait = 2; slv_rdata = 32'h0F0F0F0F;
    obs_grants.delete();
    base = obs_rsp_count;
    issue(1, 1'b0, 8'h50, 32'h0, 1);
    step();
    issue(0, 1'b1, 8'h51, 32'h51515151, 1);
    repeat (2) step();
    req_valid[0] = 1'b0; rem[0] = 0;
    wait_rsp(base + 1, 20);
    repeat (3) step();
    chk("drop_grant_count", obs_grants.size(), 1);
    if (obs_grants.size() > 0) chk("drop_grant_who", obs_grants[0], 1);
    chk("drop_rdata", obs_rsp_rdata, 32'h0F0F0F0F);

    // Reset during ACCESS aborts without a response; requester 1 then beats requester 3
    slv_never = 1;
    issue(0, 1'b0, 8'h60, 32'h0, 1);
    repeat (3) step();
    chk("pre_rst_in_access", PENABLE, 1);
    base = obs_rsp_count;
    req_valid = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    apply_reset("rst2");
    slv_never = 0; slv_wait = 0;
    step();
    chk("rst_abort_no_rsp", obs_rsp_count, base);
    obs_grants.delete();
    issue(3, 1'b1, 8'h73, 32'h73737373, 1);
    issue(1, 1'b1, 8'h71, 32'h71717171, 1);
    wait_rsp(base + 2, 30);
    chk("post_rst_grants", obs_grants.size(), 2);
    if (obs_grants.size() > 0) chk("post_rst_first", obs_grants[0], 1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-003 SHALL have parameter DATA_W, default 32, APB data width.
REQ-004 SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles to wait for PREADY.
REQ-005 SHALL have the following ports:
- PCLK  in  1  single clock; all logic samples on its rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept, one-hot or zero.
- req_write  in  NUM_REQ  per-requester direction: 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_W  shared read data; valid only with rsp_valid.
- rsp_err  out  1  error flag (PSLVERR or timeout); valid only with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB slave ready.
- PSLVERR  in  1  APB slave error.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-007 In IDLE with any req_valid set, SHALL assert req_ready for exactly one requester, chosen combinationally by round-robin starting at (last_grant+1) mod NUM_REQ.
REQ-008 A command SHALL transfer on req_valid[i] & req_ready[i] at a clock edge; the block SHALL register write/addr/wdata and owner index, update last_grant=i, and go to SETUP.
REQ-009 req_ready SHALL be all-zero in SETUP and ACCESS; requesters SHALL hold req_valid and command stable until accepted.
REQ-010 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from the registered command; SHALL go to ACCESS after exactly one cycle.
REQ-011 ACCESS: PSEL=1, PENABLE=1, with PADDR/PWRITE/PWDATA held stable; SHALL sample PREADY on each edge.
REQ-012 On an edge with PREADY=1 in ACCESS, SHALL complete in the next cycle:
- rsp_valid[owner]=1 for one cycle.
- rsp_rdata = PRDATA captured on a read, 0 on a write.
- rsp_err = PSLVERR.
- PSEL=PENABLE=0.
- state returns to IDLE.
REQ-013 SHALL count ACCESS cycles with PREADY=0; on reaching TIMEOUT, SHALL complete as in REQ-012 with rsp_err=1 and rsp_rdata=0.
REQ-014 After a completion, SHALL spend at least one IDLE cycle before the next SETUP, so the minimum transfer is 3 cycles (accept, SETUP, ACCESS).
REQ-015 With NUM_REQ requesters continuously valid, each SHALL be granted exactly once per NUM_REQ transfers.
REQ-016 In IDLE, PADDR/PWRITE/PWDATA SHALL hold their last values; PSEL=PENABLE=0.
REQ-017 A requester dropping req_valid before acceptance SHALL NOT be granted; PRDATA/PSLVERR SHALL be ignored outside the completing ACCESS edge.

Reset
REQ-018 PRESETn low SHALL immediately force: state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-019 Reset asserted mid-transfer SHALL abort the transfer without a rsp_valid pulse; the first request after deassertion SHALL follow REQ-007.
REQ-020 req_ready SHALL be 0 while PRESETn is low.

Verification
REQ-021 Single write: req0 write addr 0x10, data 0xA5A5A5A5, PREADY=1 -> APB SETUP then ACCESS with those values; rsp_valid[0] pulses, rsp_err=0.
REQ-022 Read with 3 wait states: req2 read addr 0x24, PREADY low 3 cycles, PRDATA=0x12345678 -> rsp_valid[2], rsp_rdata=0x12345678, PENABLE high 4 cycles.
REQ-023 Round-robin: all 4 requesters valid after reset -> grant order 0,1,2,3,0; no requester starved.
REQ-024 Error/timeout: PSLVERR=1 with PREADY -> rsp_err=1; PREADY never high -> rsp_err=1 after 16 ACCESS cycles, then PSEL=0.
REQ-025 Reset during ACCESS -> all outputs at reset values immediately, no rsp_valid; next request from req1 is granted first.
